y_packer: RTL and testbench

- Downstream neighbour of the RGB-to-luma converter.
- Accepts one 4-bit luma (Y) pixel per handshake and tracks raster position (x, y).
- Packs pixels into 16-bit words for the framebuffer/line-buffer write path.
- Output is a 2-entry FIFO with valid/ready; line-end and frame-end tags travel with each word.

---
 rtl/y_packer.sv | 200 ++++++++++++++++++++
 tb/tb_y_packer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/y_packer.sv
`default_nettype none
// ============================================================================
//  Module   : y_packer
//  Purpose  : Packs 4-bit luma pixels into 16-bit words (4 pixels per word)
//             while tracking raster position. Words leave through a 2-entry
//             valid/ready FIFO carrying line-end / frame-end tags.
//             Optional macro Y_MONO_DITHER_EN adds a 1-bit 4x4 Bayer
//             dithered mode (16 pixels per word), selected by the mono input
//             latched on the first pixel of each frame.
//  Revision : 1.0  initial release
// ============================================================================
module y_packer #(
  parameter int H_ACTIVE = 1600,
  parameter int V_ACTIVE = 1200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  s_y,
  input  logic        s_valid,
  input  logic        s_sof,
  output logic        s_ready,
  input  logic        mono,
  output logic [15:0] m_data,
  output logic        m_valid,
  output logic        m_eol,
  output logic        m_eof,
  input  logic        m_ready,
  output logic        sof_err
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] C_X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] C_Y_LAST = YW'(V_ACTIVE - 1);

  // Raster position, current slot and partial word
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [3:0]    r_slot;
  logic [15:0]   r_word;
  logic          r_s_ready;
  logic          r_sof_err;

  // Output FIFO storage
  logic [15:0]   r_fifo_data [2];
  logic [1:0]    r_fifo_eol;
  logic [1:0]    r_fifo_eof;
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;

  // Effective position/slot of the pixel being offered (s_sof forces origin)
  logic          w_accept;
  logic [XW-1:0] w_px_x;
  logic [YW-1:0] w_px_y;
  logic [3:0]    w_px_slot;
  logic          w_px_mono;
  logic          w_mono_bit;
  logic [3:0]    w_slot_last;
  logic [15:0]   w_word_next;
  logic          w_push;
  logic          w_pop;
  logic          w_eol;
  logic          w_eof;
  logic [1:0]    w_count_next;

  assign w_accept     = s_valid && r_s_ready;
  assign w_px_x       = s_sof ? '0 : r_x;
  assign w_px_y       = s_sof ? '0 : r_y;
  assign w_px_slot    = s_sof ? 4'd0 : r_slot;
  assign w_slot_last  = w_px_mono ? 4'd15 : 4'd3;
  assign w_push       = w_accept && (w_px_slot == w_slot_last);
  assign w_pop        = (r_count != 2'd0) && m_ready;
  assign w_eol        = (w_px_x == C_X_LAST);
  assign w_eof        = w_eol && (w_px_y == C_Y_LAST);
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

`ifdef Y_MONO_DITHER_EN
  logic       r_mono;
  logic [1:0] w_x_mod4;
  logic [1:0] w_y_mod4;

  function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'd0:  return 4'd0;
      4'd1:  return 4'd8;
      4'd2:  return 4'd2;
      4'd3:  return 4'd10;
      4'd4:  return 4'd12;
      4'd5:  return 4'd4;
      4'd6:  return 4'd14;
      4'd7:  return 4'd6;
      4'd8:  return 4'd3;
      4'd9:  return 4'd11;
      4'd10: return 4'd1;
      4'd11: return 4'd9;
      4'd12: return 4'd15;
      4'd13: return 4'd7;
      4'd14: return 4'd13;
      default: return 4'd5;
    endcase
  endfunction

  assign w_x_mod4   = 2'(w_px_x);
  assign w_y_mod4   = 2'(w_px_y);
  // The frame origin pixel takes the live mono request; every other pixel
  // uses the mode latched at that origin.
  assign w_px_mono  = ((w_px_x == '0) && (w_px_y == '0)) ? mono : r_mono;
  assign w_mono_bit = (s_y > bayer(w_y_mod4, w_x_mod4));

  // Latch the packing mode on every accepted pixel (only changes at origin)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mono <= 1'b0;
    end else if (w_accept) begin
      r_mono <= w_px_mono;
    end
  end
`else
  logic w_unused_mono;
  assign w_unused_mono = mono;
  assign w_px_mono     = 1'b0;
  assign w_mono_bit    = 1'b0;
`endif

  // Merge the incoming pixel into the partial word; slot 0 starts a fresh word
  always_comb begin
    w_word_next = (w_px_slot == 4'd0) ? 16'h0000 : r_word;
    if (w_px_mono) begin
      w_word_next[w_px_slot] = w_mono_bit;
    end else begin
      w_word_next[{w_px_slot[1:0], 2'b00} +: 4] = s_y;
    end
  end

  // Raster counters, slot counter and partial word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_slot <= 4'd0;
      r_word <= 16'h0000;
    end else if (w_accept) begin
      r_slot <= w_push ? 4'd0 : (w_px_slot + 4'd1);
      r_word <= w_word_next;
      if (w_px_x == C_X_LAST) begin
        r_x <= '0;
        r_y <= (w_px_y == C_Y_LAST) ? '0 : (w_px_y + YW'(1));
      end else begin
        r_x <= w_px_x + XW'(1);
        r_y <= w_px_y;
      end
    end
  end

  // One-cycle pulse when s_sof throws away a partially filled word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sof_err <= 1'b0;
    end else begin
      r_sof_err <= w_accept && s_sof && (r_slot != 4'd0);
    end
  end

  // Two-entry output FIFO; s_ready tracks post-edge occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= 16'h0000;
      end
      r_fifo_eol <= 2'b00;
      r_fifo_eof <= 2'b00;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_s_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_word_next;
        r_fifo_eol[r_wr_ptr]  <= w_eol;
        r_fifo_eof[r_wr_ptr]  <= w_eof;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count   <= w_count_next;
      r_s_ready <= (w_count_next < 2'd2);
    end
  end

  assign s_ready = r_s_ready;
  assign sof_err = r_sof_err;
  assign m_valid = (r_count != 2'd0);
  assign m_data  = r_fifo_data[r_rd_ptr];
  assign m_eol   = r_fifo_eol[r_rd_ptr];
  assign m_eof   = r_fifo_eof[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_y_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_y_packer
//  Purpose  : Self-checking bench for y_packer (H_ACTIVE=16, V_ACTIVE=4).
//             A queue-based raster model predicts every output word; directed
//             literal expectations pin the model. Mono tests are built when
//             Y_MONO_DITHER_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_y_packer;

  localparam int H = 16;
  localparam int V = 4;
`ifdef Y_MONO_DITHER_EN
  localparam bit MONO_BUILD = 1'b1;
`else
  localparam bit MONO_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  s_y = 4'd0;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic        mono = 1'b0;
  logic        m_ready = 1'b1;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_eol;
  logic        m_eof;
  logic        sof_err;

  y_packer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst(rst), .s_y(s_y), .s_valid(s_valid), .s_sof(s_sof),
    .s_ready(s_ready), .mono(mono), .m_data(m_data), .m_valid(m_valid),
    .m_eol(m_eol), .m_eof(m_eof), .m_ready(m_ready), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [15:0] d;
    logic        eol;
    logic        eof;
  } word_t;

  word_t       q[$];
  int          bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
  int          mx = 0, my = 0, npix = 0;
  logic        mmode = 1'b0;
  logic [15:0] acc_word = 16'h0;
  logic        exp_ready = 1'b1;
  logic        exp_sof_err = 1'b0;
  logic        model_on = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      q.delete();
      mx = 0; my = 0; npix = 0; mmode = 1'b0; acc_word = 16'h0;
      exp_ready = 1'b1; exp_sof_err = 1'b0; model_on = 1'b1;
    end else if (model_on) begin
      exp_sof_err = 1'b0;
      if (q.size() > 0 && m_ready) void'(q.pop_front());
      if (s_valid && exp_ready) begin
        if (s_sof) begin
          if (npix != 0) exp_sof_err = 1'b1;
          mx = 0; my = 0; npix = 0; acc_word = 16'h0;
        end
        if (mx == 0 && my == 0) mmode = MONO_BUILD ? mono : 1'b0;
        if (mmode) acc_word[npix] = (int'(s_y) > bayer[my % 4][mx % 4]);
        else       acc_word[4*npix +: 4] = s_y;
        npix++;
        if (npix == (mmode ? 16 : 4)) begin
          q.push_back('{acc_word, (mx == H-1), (mx == H-1) && (my == V-1)});
          npix = 0;
          acc_word = 16'h0;
        end
        mx++;
        if (mx == H) begin
          mx = 0;
          my++;
          if (my == V) my = 0;
        end
      end
      exp_ready = (q.size() < 2);
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (!rst && model_on) begin
      check("s_ready", s_ready, exp_ready);
      check("sof_err", sof_err, exp_sof_err);
      check("m_valid", m_valid, q.size() > 0);
      if (q.size() > 0) begin
        check("m_data", m_data, q[0].d);
        check("m_eol", m_eol, q[0].eol);
        check("m_eof", m_eof, q[0].eof);
      end
    end
  end

  // Count delivered words and tags
  int n_words = 0, n_eol = 0, n_eof = 0;
  initial forever begin
    @(negedge clk);
    if (!rst && m_valid && m_ready) begin
      n_words++;
      if (m_eol) n_eol++;
      if (m_eof) n_eof++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [3:0] y, input logic sof);
    int   budget = 50;
    logic acc;
    s_y = y; s_sof = sof; s_valid = 1'b1;
    do begin
      acc = s_ready;
      @(posedge clk); #1;
      budget--;
    end while (!acc && budget > 0);
    check("send_accept", acc, 1'b1);
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic acc;
    cycles(3);
    rst = 1'b0;

    // Reset values
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 16'h0000);
    check("rst_m_eol", m_eol, 1'b0);
    check("rst_m_eof", m_eof, 1'b0);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_sof_err", sof_err, 1'b0);

    // First word 1,2,3,4 -> 4321, visible right after the 4th accept
    send(4'd1, 1'b1); send(4'd2, 1'b0); send(4'd3, 1'b0);
    check("t1_pre_valid", m_valid, 1'b0);
    send(4'd4, 1'b0);
    check("t1_valid", m_valid, 1'b1);
    check("t1_data", m_data, 16'h4321);
    check("t1_eol", m_eol, 1'b0);
    check("t1_eof", m_eof, 1'b0);
    check("t1_sof_err", sof_err, 1'b0);
    cycles(1);

    // Full frame: 64 pixels -> 16 words, 4 line ends, 1 frame end
    n_words = 0; n_eol = 0; n_eof = 0;
    for (int i = 0; i < H*V; i++) send(4'(i), i == 0);
    cycles(3);
    check("frame_words", n_words, 16);
    check("frame_eol", n_eol, 4);
    check("frame_eof", n_eof, 1);
    // Next frame by wrap: first word at origin, line end after 16 pixels
    send(4'd5, 1'b0); send(4'd6, 1'b0); send(4'd7, 1'b0); send(4'd8, 1'b0);
    check("wrap_data", m_data, 16'h8765);
    check("wrap_eol", m_eol, 1'b0);
    for (int i = 0; i < 12; i++) send(4'(i), 1'b0);
    check("wrap_line_eol", m_eol, 1'b1);
    check("wrap_line_eof", m_eof, 1'b0);
    cycles(2);

    // Backpressure: only two words fit, then s_ready drops
    m_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      s_y = 4'(n); s_sof = (n == 0); s_valid = 1'b1;
      acc = s_ready;
      @(posedge clk); #1;
      if (acc) n++;
    end
    s_valid = 1'b0; s_sof = 1'b0;
    check("bp_accepted", n, 8);
    check("bp_s_ready", s_ready, 1'b0);
    check("bp_held", m_data, 16'h3210);
    cycles(3);
    check("bp_held_stable", m_data, 16'h3210);
    check("bp_valid", m_valid, 1'b1);
    m_ready = 1'b1;
    cycles(1);
    check("bp_second", m_data, 16'h7654);
    check("bp_ready_back", s_ready, 1'b1);
    cycles(1);
    check("bp_drained", m_valid, 1'b0);

    // s_sof with a partial word: discard and restart at slot 0
    send(4'd1, 1'b0); send(4'd2, 1'b0);
    send(4'd9, 1'b1);
    check("sof_err_pulse", sof_err, 1'b1);
    send(4'd10, 1'b0);
    check("sof_err_once", sof_err, 1'b0);
    send(4'd11, 1'b0); send(4'd12, 1'b0);
    check("sof_restart", m_data, 16'hCBA9);
    cycles(2);

`ifdef Y_MONO_DITHER_EN
    // Mono frame: line 0 Y=8, line 1 Y=8 with mono toggled off, line 2 Y=0,
    // line 3 Y=15; then next frame line 0 Y=15
    mono = 1'b1;
    for (int i = 0; i < 16; i++) send(4'd8, i == 0);
    check("mono_l0_y8", m_data, 16'h5555);
    mono = 1'b0;
    for (int i = 0; i < 16; i++) send(4'd8, 1'b0);
    check("mono_l1_toggle", m_data, 16'hAAAA);
    for (int i = 0; i < 16; i++) send(4'd0, 1'b0);
    check("mono_l2_y0", m_data, 16'h0000);
    for (int i = 0; i < 16; i++) send(4'd15, 1'b0);
    check("mono_l3_y15", m_data, 16'hEEEE);
    check("mono_l3_eof", m_eof, 1'b1);
    mono = 1'b1;
    for (int i = 0; i < 16; i++) send(4'd15, 1'b0);
    check("mono_f2_l0_y15", m_data, 16'hFFFF);
    mono = 1'b0;
    cycles(2);
`else
    // mono request is ignored without the dither build
    mono = 1'b1;
    send(4'd1, 1'b1); send(4'd2, 1'b0); send(4'd3, 1'b0); send(4'd4, 1'b0);
    check("mono_ignored", m_data, 16'h4321);
    mono = 1'b0;
    cycles(2);
`endif

    // Reset mid-word with one word held in the FIFO
    m_ready = 1'b0;
    send(4'd1, 1'b1); send(4'd2, 1'b0); send(4'd3, 1'b0); send(4'd4, 1'b0);
    send(4'd5, 1'b0); send(4'd6, 1'b0);
    check("pre_rst_valid", m_valid, 1'b1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("mid_rst_valid", m_valid, 1'b0);
    check("mid_rst_ready", s_ready, 1'b1);
    check("mid_rst_sof_err", sof_err, 1'b0);
    m_ready = 1'b1;
    send(4'd1, 1'b0); send(4'd2, 1'b0); send(4'd3, 1'b0); send(4'd4, 1'b0);
    check("post_rst_word", m_data, 16'h4321);
    check("post_rst_sof_err", sof_err, 1'b0);
    cycles(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
